arm_multicycle_controller: RTL and testbench

Multicycle control unit for the ARM subset (ADD/SUB/AND/ORR, LDR/STR, B). It replaces the single-cycle control path so that one shared ALU and one unified instruction/data memory can be sequenced across 3–5 cycles per instruction. The block holds the main FSM, the NZCV flag register and the registered condition result. It drives every mux select and write enable of the multicycle datapath: PC, instruction register, register file, memory, ALU and result muxes.

---
 rtl/arm_mc_pkg.sv | 35 +++
 rtl/condition_check.sv | 33 +++
 rtl/arm_multicycle_controller.sv | 154 +++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and select encodings for the ARM multicycle controller.
// Used by the controller top, its condition checker and the bench.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/condition_check.sv
// ARM condition-code evaluation against the NZCV flags {N,Z,C,V}.
// Code 1111 is treated as always-execute.
module condition_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);
    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = flags;
    assign w_ge = (w_n == w_v);

    always_comb begin
        condex = 1'b1;
        unique case (cond)
            4'b0000: condex = w_z;
            4'b0001: condex = ~w_z;
            4'b0010: condex = w_c;
            4'b0011: condex = ~w_c;
            4'b0100: condex = w_n;
            4'b0101: condex = ~w_n;
            4'b0110: condex = w_v;
            4'b0111: condex = ~w_v;
            4'b1000: condex = w_c & ~w_z;
            4'b1001: condex = ~w_c | w_z;
            4'b1010: condex = w_ge;
            4'b1011: condex = ~w_ge;
            4'b1100: condex = ~w_z & w_ge;
            4'b1101: condex = w_z | ~w_ge;
            default: condex = 1'b1;
        endcase
    end
endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: main FSM, NZCV flag register and the condition
// result latched in DECODE that gates every architectural write.
module arm_multicycle_controller
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [1:0] alucontrol,
    output logic [3:0] state
);
    state_t     r_state, w_next;
    logic [3:0] r_flags;
    logic       r_condex;
    logic       w_condex;
    logic [1:0] w_dp_alu;
    logic       w_cmd_valid;
    logic       w_pcwrite, w_irwrite, w_regwrite, w_memwrite;
    logic       w_rd_pc;
    logic       w_flag_upd;

    condition_check u_cond (
        .cond   (cond),
        .flags  (r_flags),
        .condex (w_condex)
    );

    always_comb begin
        w_cmd_valid = 1'b1;
        w_dp_alu    = ALU_ADD;
        case (funct[4:1])
            4'b0100: w_dp_alu = ALU_ADD;
            4'b0010: w_dp_alu = ALU_SUB;
            4'b0000: w_dp_alu = ALU_AND;
            4'b1100: w_dp_alu = ALU_ORR;
            default: w_cmd_valid = 1'b0;
        endcase
    end

    assign w_rd_pc    = (rd == 4'd15);
    assign w_flag_upd = ((r_state == StExecuteR) || (r_state == StExecuteI)) &&
                        funct[0] && r_condex && w_cmd_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StFetch;
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == StDecode) r_condex <= w_condex;
            if (w_flag_upd) begin
                r_flags[3:2] <= aluflags[3:2];
                // Logical ops leave carry and overflow untouched
                if (w_dp_alu == ALU_ADD || w_dp_alu == ALU_SUB) r_flags[1:0] <= aluflags[1:0];
            end
        end
    end

    always_comb begin
        w_next     = StFetch;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RD2;
        resultsrc  = RES_ALUOUT;
        alucontrol = ALU_ADD;
        case (r_state)
            StFetch: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                w_next    = StDecode;
            end
            StDecode: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                case (op)
                    OP_MEM:  w_next = StMemAdr;
                    OP_DP:   w_next = funct[5] ? StExecuteI : StExecuteR;
                    OP_B:    w_next = StBranch;
                    default: w_next = StFetch;
                endcase
            end
            StMemAdr: begin
                alusrcb = SRCB_IMM;
                w_next  = funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                adrsrc = 1'b1;
                w_next = StMemWb;
            end
            StMemWb: begin
                resultsrc  = RES_DATA;
                w_regwrite = r_condex;
                w_pcwrite  = r_condex & w_rd_pc;
            end
            StMemWr: begin
                adrsrc     = 1'b1;
                w_memwrite = r_condex;
            end
            StExecuteR: begin
                alucontrol = w_dp_alu;
                w_next     = StAluWb;
            end
            StExecuteI: begin
                alusrcb    = SRCB_IMM;
                alucontrol = w_dp_alu;
                w_next     = StAluWb;
            end
            StAluWb: begin
                w_regwrite = r_condex;
                w_pcwrite  = r_condex & w_rd_pc;
            end
            StBranch: begin
                alusrcb   = SRCB_IMM;
                resultsrc = RES_ALU;
                w_pcwrite = r_condex;
            end
            default: w_next = StFetch;
        endcase
    end

    // Write enables are held off for as long as reset is asserted
    assign pcwrite  = w_pcwrite & reset;
    assign irwrite  = w_irwrite & reset;
    assign regwrite = w_regwrite & reset;
    assign memwrite = w_memwrite & reset;

    assign immsrc = op;
    assign regsrc = {op == OP_B, (op == OP_MEM) & ~funct[0]};
    assign state  = r_state;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench: the stimulus side walks each instruction through a reference
// model and queues the expected per-cycle controls; a negedge monitor compares.
module tb_arm_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cond, rd, aluflags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc, immsrc, regsrc, alucontrol;
    logic [3:0] state;

    arm_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .aluflags   (aluflags),
        .pcwrite    (pcwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .adrsrc     (adrsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .immsrc     (immsrc),
        .regsrc     (regsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rgw, mw, adr, srca;
        logic [1:0] srcb, res, imm, rsrc, alu;
    } rec_t;

    rec_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] m_flags = 4'b0000;
    bit         rel_pending = 0;
    bit         stim_done = 0;

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Expected controls for one cycle; s = step name as its numeric state code
    function automatic rec_t exp_rec(input int s, input logic [1:0] o, input logic [5:0] f,
                                     input logic [3:0] r, input bit cx, input bit in_rst);
        rec_t e;
        e      = '0;
        e.st   = 4'(s);
        e.imm  = o;
        e.rsrc = {o == 2'b10, (o == 2'b01) && !f[0]};
        case (f[4:1])
            4'b0010: e.alu = (s == 6 || s == 7) ? 2'b01 : 2'b00;
            4'b0000: e.alu = (s == 6 || s == 7) ? 2'b10 : 2'b00;
            4'b1100: e.alu = (s == 6 || s == 7) ? 2'b11 : 2'b00;
            default: e.alu = 2'b00;
        endcase
        case (s)
            0: begin e.irw = !in_rst; e.pcw = !in_rst; e.srca = 1; e.srcb = 2; e.res = 2; end
            1: begin e.srca = 1; e.srcb = 2; e.res = 2; end
            2: e.srcb = 1;
            3: e.adr = 1;
            4: begin e.res = 1; e.rgw = cx; e.pcw = cx && (r == 15); end
            5: begin e.adr = 1; e.mw = cx; end
            7: e.srcb = 1;
            8: begin e.rgw = cx; e.pcw = cx && (r == 15); end
            9: begin e.srcb = 1; e.res = 2; e.pcw = cx; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] xf, input bit rst_mid);
        int seq[$];
        bit cx;
        case (o)
            2'b00:   seq = '{0, 1, (f[5] ? 7 : 6), 8};
            2'b01:   seq = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10:   seq = '{0, 1, 9};
            default: seq = '{0, 1};
        endcase
        cx = cond_pass(c, m_flags);
        foreach (seq[i]) begin
            @(posedge clk);
            #1;
            if (rel_pending) begin
                reset = 1'b1;
                rel_pending = 0;
            end
            cond = c; op = o; funct = f; rd = r;
            aluflags = (seq[i] == 6 || seq[i] == 7) ? xf : 4'($urandom);
            if (rst_mid && seq[i] == 3) begin
                reset = 1'b0;
                m_flags = 4'b0000;
                rel_pending = 1;
                sb.push_back(exp_rec(0, o, f, r, 0, 1));
                return;
            end
            sb.push_back(exp_rec(seq[i], o, f, r, cx, 0));
            if ((seq[i] == 6 || seq[i] == 7) && f[0] && cx) begin
                case (f[4:1])
                    4'b0100, 4'b0010: m_flags = xf;
                    4'b0000, 4'b1100: m_flags[3:2] = xf[3:2];
                    default: ;
                endcase
            end
        end
    endtask

    initial begin : monitor
        rec_t got, e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = '{state, pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca,
                        alusrcb, resultsrc, immsrc, regsrc, alucontrol};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL cycle t=%0t: got st=%0d pc/ir/rg/mw=%b%b%b%b adr=%b a=%b b=%b res=%b imm=%b rs=%b alu=%b, required st=%0d pc/ir/rg/mw=%b%b%b%b adr=%b a=%b b=%b res=%b imm=%b rs=%b alu=%b",
                             $time, got.st, got.pcw, got.irw, got.rgw, got.mw, got.adr,
                             got.srca, got.srcb, got.res, got.imm, got.rsrc, got.alu,
                             e.st, e.pcw, e.irw, e.rgw, e.mw, e.adr, e.srca, e.srcb,
                             e.res, e.imm, e.rsrc, e.alu);
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0] cmds [5];
        logic [3:0] c, r, cmd;
        logic [1:0] o;
        logic [5:0] f;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0111};
        reset = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'b0; rd = 4'd0; aluflags = 4'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            sb.push_back(exp_rec(0, op, funct, rd, 0, 1));
        end
        rel_pending = 1;

        run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'($urandom), 0);  // ADD R1
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0, 0);         // LDR R15
        run_instr(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100, 0);       // SUBS -> Z
        run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0, 0);          // BEQ taken
        run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0, 0);          // BNE not taken
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd3, 4'b0011, 0);       // ADDS -> 0011
        run_instr(4'b1110, 2'b00, 6'b000001, 4'd4, 4'b1000, 0);       // ANDS -> 1011
        run_instr(4'b0100, 2'b10, 6'b0, 4'd0, 4'b0, 0);               // BMI taken
        run_instr(4'b0110, 2'b10, 6'b0, 4'd0, 4'b0, 0);               // BVS taken
        run_instr(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100, 0);       // SUBS -> Z
        run_instr(4'b0001, 2'b01, 6'b011000, 4'd5, 4'b0, 0);          // STRNE suppressed
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd6, 4'b0, 1);          // LDR, reset in MEMRD
        run_instr(4'b0000, 2'b10, 6'b0, 4'd0, 4'b0, 0);               // flags cleared: BEQ fails

        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
            o = 2'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cmd = cmds[$urandom_range(0, 4)];
            f = (o == 2'b00) ? {1'($urandom), cmd, 1'($urandom)} : 6'($urandom);
            run_instr(c, o, f, r, 4'($urandom), (o == 2'b01) && ($urandom_range(0, 9) == 0));
        end
        if (rel_pending) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            sb.push_back(exp_rec(0, op, funct, rd, 0, 0));
        end

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
